regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Single-write-port scheduler for the CPU's 32x32 register file. It shares the one write port between three requesters: the CPU writeback stage, the external IO input path (switch/peripheral data loaded into a GPR such as $t9), and the debug/loader port. CPU writeback has fixed priority. IO and debug alternate round-robin. A starvation counter forces a one-cycle CPU stall so side requesters always make progress. The block sits between the decode/writeback logic and the register array, and drives the array's write enable, address and data.

## Interface
- STARVE_LIMIT, 8: number of consecutive cycles a side request may wait before a stall is forced. Legal range 2..15.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_we  in  1  CPU writeback write request, valid this cycle only.
- cpu_waddr  in  5  CPU destination register.
- cpu_wdata  in  32  CPU write data.
- io_req  in  1  IO write request; held high with stable addr/data until io_ack.
- io_addr  in  5  IO destination register.
- io_data  in  32  IO write data.
- io_ack  out  1  one-cycle pulse: IO write committed.
- dbg_req  in  1  debug write request; same handshake as IO.
- dbg_addr  in  5  debug destination register.
- dbg_data  in  32  debug write data.
- dbg_ack  out  1  one-cycle pulse: debug write committed.
- cpu_stall  out  1  registered; CPU pipeline must hold and keep cpu_we low for this cycle.
- rf_we  out  1  registered write enable to the register array.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  32  registered write data.
- stall_violation  out  1  sticky; set when cpu_we=1 while cpu_stall=1.

## Operation
- Arbitration is evaluated every cycle from the inputs and the current state. The result is registered at the rising edge.
- Eligible side requester: io_req=1 and io_ack=0 (for IO), or dbg_req=1 and dbg_ack=0 (for debug). The ack mask prevents a request that is still high in its ack cycle from being granted twice.
- Priority:
  1. cpu_we=1 wins unconditionally, including during cpu_stall (in that case stall_violation is also set).
  2. Otherwise, if exactly one side requester is eligible, it wins.
  3. If both are eligible, the one not named by rr_last wins. rr_last updates to the winner on every side grant. Reset value of rr_last = debug, so IO wins the first tie.
- Winner's addr/data go to rf_waddr/rf_wdata. rf_we=1 unless the address is 0.
  - Writes to register 0 are dropped: rf_we=0, but a side requester is still acked.
- Every side grant produces an ack pulse in the same registered cycle as the rf_* outputs.
- Starvation counter wait_cnt, 4 bits:
  - Increments each cycle in which at least one side requester is eligible and the CPU wins.
  - Clears on any side grant, or when no side requester is eligible.
  - Saturates at STARVE_LIMIT.
  - When wait_cnt reaches STARVE_LIMIT-1 and the CPU wins again, cpu_stall is registered high for the next cycle.
- States: RUN, STALL.
  - RUN -> STALL on the starvation condition above.
  - STALL lasts exactly one cycle, then returns to RUN.
  - In STALL with cpu_we=0, the side requester chosen by normal arbitration is granted.
  - In STALL with cpu_we=1 (violation), the CPU wins, wait_cnt holds its value, and STALL is re-entered next cycle.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, io_ack=0, dbg_ack=0, cpu_stall=0, stall_violation=0, wait_cnt=0, rr_last=debug, state=RUN.
- Reset mid-handshake: pending requests are forgotten and no ack is issued. Requesters re-present after reset deasserts.
- Latency: inputs sampled at edge N appear on rf_* and ack at edge N, visible during cycle N..N+1. The array commits at edge N+1.
- Minimum side-write period per requester is 2 cycles (request cycle, then ack cycle).
- A requester may present a new request in the cycle after its ack is seen.
- cpu_stall is high for exactly one cycle per starvation event. The worst-case side wait is STARVE_LIMIT+1 cycles.
- Simultaneous CPU write and side write to the same register: the CPU write is committed first, the side write on a later cycle. Last writer wins.

## Test plan
- Reset, then io_req with addr 25, data 0x0000_00A5, cpu_we=0 -> next cycle rf_we=1, rf_waddr=25, rf_wdata=0xA5, io_ack=1 for one cycle only.
- io_req and dbg_req held continuously with no CPU traffic -> grants alternate IO, debug, IO, debug, with each ack separated by the mask cycle.
- cpu_we=1 every cycle plus io_req held, STARVE_LIMIT=8 -> cpu_stall=1 exactly one cycle after 8 CPU-won cycles, IO granted in that cycle, wait_cnt back to 0.
- dbg_req to addr 0, data 0xFFFF_FFFF -> rf_we=0, dbg_ack=1.
- cpu_we=1 during cpu_stall -> CPU write committed, stall_violation=1 stays set until reset, cpu_stall reasserted the next cycle.
- Assert reset while io_req is pending and unacked -> no io_ack, all outputs 0 on the cycle after reset.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Arbiter for the register file's single write port: CPU writeback has fixed priority,
// IO and debug share the leftover slots round-robin, and a starvation counter forces a CPU stall.
module regfile_write_scheduler #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_waddr,
    input  logic [31:0] cpu_wdata,
    input  logic        io_req,
    input  logic [4:0]  io_addr,
    input  logic [31:0] io_data,
    output logic        io_ack,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ack,
    output logic        cpu_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_violation
);

    localparam logic [0:0] STATE_RUN   = 1'b0;
    localparam logic [0:0] STATE_STALL = 1'b1;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic        rrLastDbg_q, rrLastDbg_d;
    logic        rfWe_q, rfWe_d;
    logic [4:0]  rfWaddr_q, rfWaddr_d;
    logic [31:0] rfWdata_q, rfWdata_d;
    logic        ioAck_q, ioAck_d;
    logic        dbgAck_q, dbgAck_d;
    logic        violation_q, violation_d;

    logic ioElig, dbgElig, anyElig;
    logic grantIo, grantDbg, sideGrant, inStall;

    // A request still high during its own ack cycle must not be granted a second time.
    assign ioElig    = io_req & ~ioAck_q;
    assign dbgElig   = dbg_req & ~dbgAck_q;
    assign anyElig   = ioElig | dbgElig;
    assign grantIo   = ~cpu_we & ioElig & (~dbgElig | rrLastDbg_q);
    assign grantDbg  = ~cpu_we & dbgElig & (~ioElig | ~rrLastDbg_q);
    assign sideGrant = grantIo | grantDbg;
    assign inStall   = (state_q == STATE_STALL);

    always_comb begin
        rfWe_d      = 1'b0;
        rfWaddr_d   = rfWaddr_q;
        rfWdata_d   = rfWdata_q;
        ioAck_d     = grantIo;
        dbgAck_d    = grantDbg;
        rrLastDbg_d = rrLastDbg_q;
        violation_d = violation_q | (cpu_we & inStall);
        waitCnt_d   = waitCnt_q;
        state_d     = STATE_RUN;

        if (cpu_we) begin
            rfWe_d    = (cpu_waddr != 5'd0);
            rfWaddr_d = cpu_waddr;
            rfWdata_d = cpu_wdata;
        end else if (grantIo) begin
            rfWe_d      = (io_addr != 5'd0);
            rfWaddr_d   = io_addr;
            rfWdata_d   = io_data;
            rrLastDbg_d = 1'b0;
        end else if (grantDbg) begin
            rfWe_d      = (dbg_addr != 5'd0);
            rfWaddr_d   = dbg_addr;
            rfWdata_d   = dbg_data;
            rrLastDbg_d = 1'b1;
        end

        // A CPU write during a stall keeps the count frozen and forces another stall cycle.
        if (sideGrant || !anyElig) begin
            waitCnt_d = 4'd0;
        end else if (!inStall && (waitCnt_q < LIMIT)) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end

        if (inStall) begin
            state_d = cpu_we ? STATE_STALL : STATE_RUN;
        end else if (cpu_we && anyElig && (waitCnt_q >= LIMIT_M1)) begin
            state_d = STATE_STALL;
        end
    end

    // Synchronous reset drops any half-finished handshake without acking it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= STATE_RUN;
            waitCnt_q   <= 4'd0;
            rrLastDbg_q <= 1'b1;
            rfWe_q      <= 1'b0;
            rfWaddr_q   <= 5'd0;
            rfWdata_q   <= 32'd0;
            ioAck_q     <= 1'b0;
            dbgAck_q    <= 1'b0;
            violation_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            rrLastDbg_q <= rrLastDbg_d;
            rfWe_q      <= rfWe_d;
            rfWaddr_q   <= rfWaddr_d;
            rfWdata_q   <= rfWdata_d;
            ioAck_q     <= ioAck_d;
            dbgAck_q    <= dbgAck_d;
            violation_q <= violation_d;
        end
    end

    assign io_ack          = ioAck_q;
    assign dbg_ack         = dbgAck_q;
    assign cpu_stall       = inStall;
    assign rf_we           = rfWe_q;
    assign rf_waddr        = rfWaddr_q;
    assign rf_wdata        = rfWdata_q;
    assign stall_violation = violation_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed vector table, hand-written stall/reset
// sequences, and a randomized run against a rule-level reference model.
module tb_regfile_write_scheduler;

    localparam int LIMIT = 8;
    localparam int W_NONE = 0;
    localparam int W_CPU  = 1;
    localparam int W_IO   = 2;
    localparam int W_DBG  = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_we = 1'b0;
    logic [4:0]  cpu_waddr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        io_req = 1'b0;
    logic [4:0]  io_addr = '0;
    logic [31:0] io_data = '0;
    logic        io_ack;
    logic        dbg_req = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data = '0;
    logic        dbg_ack;
    logic        cpu_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_violation;

    int checks = 0;
    int failures = 0;

    regfile_write_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .io_req(io_req), .io_addr(io_addr), .io_data(io_data), .io_ack(io_ack),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .cpu_stall(cpu_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_violation(stall_violation)
    );

    always #5 clock = ~clock;

    // Reference model state: expected outputs plus the arbitration bookkeeping.
    bit          mWe, mIoAck, mDbgAck, mStall, mViol, mRrDbg;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    int          mWait;

    typedef struct {
        logic        cpuWe;
        logic [4:0]  cpuAddr;
        logic [31:0] cpuData;
        logic        ioReq;
        logic [4:0]  ioAddr;
        logic [31:0] ioData;
        logic        dbgReq;
        logic [4:0]  dbgAddr;
        logic [31:0] dbgData;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expIoAck;
        logic        expDbgAck;
    } vec_t;

    vec_t vecs[12];

    task automatic modelStep();
        bit ioOk, dbgOk, nextStall;
        int winner;
        if (reset) begin
            mWe = 0; mAddr = '0; mData = '0; mIoAck = 0; mDbgAck = 0;
            mStall = 0; mViol = 0; mWait = 0; mRrDbg = 1;
            return;
        end
        ioOk  = io_req && !mIoAck;
        dbgOk = dbg_req && !mDbgAck;
        if (cpu_we)              winner = W_CPU;
        else if (ioOk && dbgOk)  winner = mRrDbg ? W_IO : W_DBG;
        else if (ioOk)           winner = W_IO;
        else if (dbgOk)          winner = W_DBG;
        else                     winner = W_NONE;

        if (cpu_we && mStall) mViol = 1;
        nextStall = cpu_we && (mStall || ((ioOk || dbgOk) && mWait >= LIMIT - 1));
        if (winner == W_IO || winner == W_DBG || !(ioOk || dbgOk)) mWait = 0;
        else if (!mStall) mWait = (mWait + 1 > LIMIT) ? LIMIT : mWait + 1;
        mStall = nextStall;

        mIoAck  = (winner == W_IO);
        mDbgAck = (winner == W_DBG);
        if (winner == W_IO)  mRrDbg = 0;
        if (winner == W_DBG) mRrDbg = 1;
        mWe = 0;
        case (winner)
            W_CPU: begin mAddr = cpu_waddr; mData = cpu_wdata; end
            W_IO:  begin mAddr = io_addr;   mData = io_data;   end
            W_DBG: begin mAddr = dbg_addr;  mData = dbg_data;  end
            default: ;
        endcase
        if (winner != W_NONE) mWe = (mAddr != 5'd0);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".rf_we"}, 32'(rf_we), 32'(mWe));
        checkVal({tag, ".io_ack"}, 32'(io_ack), 32'(mIoAck));
        checkVal({tag, ".dbg_ack"}, 32'(dbg_ack), 32'(mDbgAck));
        checkVal({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(mStall));
        checkVal({tag, ".stall_violation"}, 32'(stall_violation), 32'(mViol));
        if (mWe || mIoAck || mDbgAck) begin
            checkVal({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(mAddr));
            checkVal({tag, ".rf_wdata"}, rf_wdata, mData);
        end
    endtask

    task automatic clearInputs();
        cpu_we = 0; cpu_waddr = '0; cpu_wdata = '0;
        io_req = 0; io_addr = '0; io_data = '0;
        dbg_req = 0; dbg_addr = '0; dbg_data = '0;
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, ".rf_we"}, 32'(rf_we), 32'd0);
        checkVal({tag, ".rf_waddr"}, 32'(rf_waddr), 32'd0);
        checkVal({tag, ".rf_wdata"}, rf_wdata, 32'd0);
        checkVal({tag, ".io_ack"}, 32'(io_ack), 32'd0);
        checkVal({tag, ".dbg_ack"}, 32'(dbg_ack), 32'd0);
        checkVal({tag, ".cpu_stall"}, 32'(cpu_stall), 32'd0);
        checkVal({tag, ".stall_violation"}, 32'(stall_violation), 32'd0);
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        cpu_we = v.cpuWe;   cpu_waddr = v.cpuAddr; cpu_wdata = v.cpuData;
        io_req = v.ioReq;   io_addr = v.ioAddr;    io_data = v.ioData;
        dbg_req = v.dbgReq; dbg_addr = v.dbgAddr;  dbg_data = v.dbgData;
        tick();
    endtask

    // Holds io_req with CPU writes every cycle until the starvation stall should appear.
    task automatic starve(input string tag);
        io_req = 1; io_addr = 5'd5; io_data = 32'h55;
        for (int k = 1; k <= LIMIT; k++) begin
            cpu_we = 1; cpu_waddr = 5'(k); cpu_wdata = 32'(k);
            tick();
            checkOutput($sformatf("%s.cyc%0d", tag, k));
            checkVal($sformatf("%s.stall%0d", tag, k), 32'(cpu_stall), 32'(k == LIMIT));
        end
    endtask

    initial begin
        vecs[0]  = '{0, 5'd0, 32'h0,    1, 5'd3,  32'h33, 1, 5'd4, 32'h44,       1, 5'd3,  32'h33,       1, 0};
        vecs[1]  = '{0, 5'd0, 32'h0,    1, 5'd3,  32'h33, 1, 5'd4, 32'h44,       1, 5'd4,  32'h44,       0, 1};
        vecs[2]  = '{0, 5'd0, 32'h0,    1, 5'd3,  32'h33, 1, 5'd4, 32'h44,       1, 5'd3,  32'h33,       1, 0};
        vecs[3]  = '{0, 5'd0, 32'h0,    1, 5'd3,  32'h33, 1, 5'd4, 32'h44,       1, 5'd4,  32'h44,       0, 1};
        vecs[4]  = '{0, 5'd0, 32'h0,    0, 5'd0,  32'h0,  0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 0};
        vecs[5]  = '{0, 5'd0, 32'h0,    1, 5'd25, 32'hA5, 0, 5'd0, 32'h0,        1, 5'd25, 32'hA5,       1, 0};
        vecs[6]  = '{0, 5'd0, 32'h0,    1, 5'd25, 32'hA5, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 0};
        vecs[7]  = '{0, 5'd0, 32'h0,    0, 5'd0,  32'h0,  1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'hFFFFFFFF, 0, 1};
        vecs[8]  = '{0, 5'd0, 32'h0,    0, 5'd0,  32'h0,  1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,        0, 0};
        vecs[9]  = '{1, 5'd9, 32'h1234, 1, 5'd9,  32'h99, 0, 5'd0, 32'h0,        1, 5'd9,  32'h1234,     0, 0};
        vecs[10] = '{0, 5'd0, 32'h0,    1, 5'd9,  32'h99, 0, 5'd0, 32'h0,        1, 5'd9,  32'h99,       1, 0};
        vecs[11] = '{0, 5'd0, 32'h0,    1, 5'd9,  32'h99, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 0};

        doReset();
        checkResetState("reset");

        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            checkOutput(tag);
            checkVal({tag, ".tbl_we"}, 32'(rf_we), 32'(vecs[i].expWe));
            checkVal({tag, ".tbl_io_ack"}, 32'(io_ack), 32'(vecs[i].expIoAck));
            checkVal({tag, ".tbl_dbg_ack"}, 32'(dbg_ack), 32'(vecs[i].expDbgAck));
            if (vecs[i].expWe || vecs[i].expIoAck || vecs[i].expDbgAck) begin
                checkVal({tag, ".tbl_addr"}, 32'(rf_waddr), 32'(vecs[i].expAddr));
                checkVal({tag, ".tbl_data"}, rf_wdata, vecs[i].expData);
            end
        end

        // Starvation: the stall cycle grants IO, and the counter must restart from zero.
        doReset();
        starve("starve");
        cpu_we = 0;
        tick();
        checkOutput("starve.grant");
        checkVal("starve.grant_ack", 32'(io_ack), 32'd1);
        checkVal("starve.grant_addr", 32'(rf_waddr), 32'd5);
        checkVal("starve.grant_stall", 32'(cpu_stall), 32'd0);
        for (int k = 1; k <= LIMIT + 1; k++) begin
            cpu_we = 1; cpu_waddr = 5'd1; cpu_wdata = 32'(k);
            tick();
            checkOutput($sformatf("restarve.cyc%0d", k));
            checkVal($sformatf("restarve.stall%0d", k), 32'(cpu_stall), 32'(k == LIMIT + 1));
        end

        // Violation: CPU writes during the stall cycle.
        doReset();
        starve("viol");
        cpu_we = 1; cpu_waddr = 5'd10; cpu_wdata = 32'hAA;
        tick();
        checkOutput("viol.cpu");
        checkVal("viol.we", 32'(rf_we), 32'd1);
        checkVal("viol.addr", 32'(rf_waddr), 32'd10);
        checkVal("viol.flag", 32'(stall_violation), 32'd1);
        checkVal("viol.restall", 32'(cpu_stall), 32'd1);
        cpu_we = 0;
        tick();
        checkOutput("viol.release");
        checkVal("viol.release_ack", 32'(io_ack), 32'd1);
        checkVal("viol.release_stall", 32'(cpu_stall), 32'd0);
        io_req = 0;
        tick();
        checkVal("viol.sticky", 32'(stall_violation), 32'd1);
        doReset();
        checkResetState("viol.reset");

        // Reset while IO is pending and unacked.
        io_req = 1; io_addr = 5'd12; io_data = 32'hC;
        cpu_we = 1; cpu_waddr = 5'd2; cpu_wdata = 32'h2;
        tick();
        checkOutput("midrst.pending");
        checkVal("midrst.pending_ack", 32'(io_ack), 32'd0);
        cpu_we = 0;
        reset = 1;
        tick();
        checkVal("midrst.during_ack", 32'(io_ack), 32'd0);
        reset = 0;
        clearInputs();
        tick();
        checkResetState("midrst.after");

        // Randomized traffic with requesters honouring the handshake.
        doReset();
        for (int blk = 0; blk < 12; blk++) begin
            int cpuPct;
            cpuPct = 50 + (blk % 4) * 15;
            for (int c = 0; c < 250; c++) begin
                if (io_req && io_ack) begin
                    io_req = 1'($urandom_range(0, 1));
                    io_addr = 5'($urandom_range(0, 31)); io_data = $urandom;
                end else if (!io_req && $urandom_range(0, 2) == 0) begin
                    io_req = 1; io_addr = 5'($urandom_range(0, 31)); io_data = $urandom;
                end
                if (dbg_req && dbg_ack) begin
                    dbg_req = 1'($urandom_range(0, 1));
                    dbg_addr = 5'($urandom_range(0, 31)); dbg_data = $urandom;
                end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
                    dbg_req = 1; dbg_addr = 5'($urandom_range(0, 31)); dbg_data = $urandom;
                end
                cpu_we = (!mStall || $urandom_range(0, 99) == 0) && ($urandom_range(0, 99) < cpuPct);
                cpu_waddr = 5'($urandom_range(0, 31));
                cpu_wdata = $urandom;
                tick();
                checkOutput($sformatf("rand.b%0d.c%0d", blk, c));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
